// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/write-back over a shared
// req/ack memory port, with retired-instruction count and timeout/illegal-opcode error.
module cpu_sequencer #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               zero,
    output logic               mem_req,
    output logic               mem_sel,
    output logic               mem_we,
    output logic [3:0]         opcode,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_en,
    output logic               alu_en,
    output logic               reg_we,
    output logic               pc_en,
    output logic               pc_sel,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [15:0]        retired
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [15:0]         retired_q, retired_d;
    logic [3:0]          op;
    logic                timed_out;

    assign op        = ir_q[INSTR_W-1 -: 4];
    assign timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        ir_en   = 1'b0;
        pc_en   = 1'b0;
        pc_sel  = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_en   = 1'b1;
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (op[1:0] == 2'b11)  state_d = S_ERR;
                else if (op == 4'b0000) state_d = S_HALT;
                else                    state_d = S_EXEC;
            end
            S_EXEC: begin
                wait_d = '0;
                if (op[0] | op[1]) begin
                    state_d = S_MEM;
                end else if (op[3]) begin
                    state_d = S_WB;
                end else begin
                    pc_en   = 1'b1;
                    pc_sel  = op[2] & zero;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op[1]) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                pc_en   = 1'b1;
                state_d = S_FETCH;
                wait_d  = '0;
            end
            default: state_d = S_ERR;
        endcase
        retired_d = retired_q + 16'(pc_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Moore outputs decode straight from state so reset drops them without waiting for a clock.
    assign mem_req = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_sel = (state_q == S_MEM);
    assign mem_we  = (state_q == S_MEM) && op[1];
    assign alu_en  = (state_q == S_EXEC);
    assign reg_we  = (state_q == S_WB);
    assign busy    = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR));
    assign halted  = (state_q == S_HALT);
    assign err     = (state_q == S_ERR);
    assign opcode  = op;
    assign ir      = ir_q;
    assign retired = retired_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle sequencer for the custom CPU datapath. It steps each instruction through fetch, decode, execute, memory and write-back, and shares the single memory port between instruction fetch and data access using a req/ack handshake. It holds the instruction register, drives the 4-bit opcode to the combinational control decoder, and gates the datapath enables (IR load, PC update, ALU, register write). It also counts retired instructions and flags memory timeouts and illegal opcodes.

## Interface
- INSTR_W, 16, instruction width; opcode is IR[INSTR_W-1:INSTR_W-4]
- TIMEOUT, 15, maximum cycles to wait for mem_ack in FETCH or MEM
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE or HALT
- mem_ack  in  1  memory done; sampled only while mem_req=1
- mem_rdata  in  INSTR_W  memory read data; captured into IR on fetch ack
- zero  in  1  ALU zero flag; sampled in EXEC
- mem_req  out  1  memory request
- mem_sel  out  1  0 = instruction fetch, 1 = data access
- mem_we  out  1  data write (store)
- opcode  out  4  IR opcode field, to control decoder
- ir  out  INSTR_W  instruction register
- ir_en  out  1  IR load strobe
- alu_en  out  1  ALU operand/result latch enable
- reg_we  out  1  register file write strobe
- pc_en  out  1  PC update strobe
- pc_sel  out  1  1 = branch target, 0 = PC+1; valid only with pc_en
- busy  out  1  state is not IDLE, HALT or ERR
- halted  out  1  in HALT
- err  out  1  in ERR (sticky until rst)
- retired  out  16  retired-instruction count

## Operation
- **Opcode classes:** op[0] = load, op[1] = store, op[2] = branch, op[3] = ALU.
  - op[1:0] = 2'b11 is illegal.
  - 4'b0000 is HALT.
- **IDLE:** on start, go to FETCH.
- **FETCH:** mem_req=1, mem_sel=0, mem_we=0.
  - On mem_ack: ir_en=1 and IR <= mem_rdata in the same cycle, then go to DECODE.
- **DECODE:** one cycle.
  - op[1:0]=11: go to ERR.
  - op=0000: go to HALT.
  - Otherwise: go to EXEC.
- **EXEC:** alu_en=1.
  - op[0]|op[1]: go to MEM.
  - Else if op[3]: go to WB.
  - Else: pc_en=1, pc_sel=op[2]&zero, go to FETCH.
- **MEM:** mem_req=1, mem_sel=1, mem_we=op[1].
  - On ack with a load: go to WB.
  - On ack with a store: pc_en=1, pc_sel=0, go to FETCH.
- **WB:** reg_we=1, pc_en=1, pc_sel=0, go to FETCH.
- **HALT:** halted=1. On start, go to FETCH (PC unchanged).
- **ERR:** err=1. No exit except rst.
- **Timeout:** the wait counter clears on entry to FETCH or MEM and increments each cycle without ack. If cycle TIMEOUT of the state ends without ack, go to ERR with mem_req dropping.
- **Retired counter:** retired increments on every pc_en and wraps 16'hFFFF to 0.
- **start handling:** ignored in every state other than IDLE and HALT.

## Timing
- **Reset values:** state=IDLE, IR=0, retired=0, wait counter=0, all outputs 0. This applies asynchronously, including mid-handshake; mem_req drops immediately.
- **Output types:**
  - mem_req, mem_sel, mem_we, alu_en, reg_we, busy, halted and err are Moore outputs (decoded from state).
  - ir_en and the pc_en/pc_sel pulses from EXEC and MEM are combinational on state and ack.
  - All strobes last exactly one cycle.
- **Ack timing:** mem_ack may arrive in the first cycle of FETCH or MEM. Minimum instruction latency with zero-wait memory:
  - branch/nop: 3 cycles
  - ALU: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - Each wait cycle adds 1.
- **Handshake rules:** mem_req stays high until ack or timeout. An ack while mem_req=0 is ignored. mem_sel and mem_we are stable throughout a request.
- **Timeout boundary:** an ack in cycle TIMEOUT is accepted. A missing ack at the end of cycle TIMEOUT means ERR on the next edge.

## Test plan
- **Reset:** rst mid-FETCH with mem_req=1 -> mem_req=0 immediately; after release all outputs 0 and retired=0; start -> FETCH next cycle.
- **ALU instruction:** ALU op 4'b1000, zero-wait ack -> ir_en in cycle 1, alu_en in cycle 3, reg_we+pc_en in cycle 4, retired=1.
- **Load then store:** load 4'b0001 then store 4'b0010, ack after 2 wait cycles each:
  - load: mem_sel=1, mem_we=0, WB follows, 7 cycles total
  - store: mem_we=1, no reg_we, pc_en on ack
- **Branch:** branch 4'b0100 with zero=1 -> pc_en=1, pc_sel=1 in EXEC. With zero=0 -> pc_sel=0. No mem_sel=1 cycle in either case.
- **Timeout:** TIMEOUT=15, mem_ack withheld in FETCH -> mem_req high for exactly 15 cycles, err=1 after that, stays set until rst. Repeat with ack in cycle 15 -> normal DECODE.
- **HALT, illegal opcode and wrap:**
  - opcode 0000 -> halted=1, start ignored while busy, start in HALT -> FETCH.
  - opcode 4'b0011 -> err=1 after DECODE.
  - Preload 16'hFFFF retirements -> retired wraps to 0.
